mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Sequences and shares the single byte-addressed, word-wide ram between the
//   instruction-fetch port (I) and the load/store port (D). Arbitrates round-robin.
//   Performs sub-word loads with sign/zero extension and sub-word stores by
//   read-modify-write. Flags misaligned accesses and illegal access sizes.
//   Sits between the CPU core and the ram instance.
// PARAMETERS
//   N     32    data width (fixed 32; byte lanes [7:0]..[31:24])
//   SIZE  1024  ram size in bytes; must be a multiple of 4
// PORTS
//   clk         in   1             clock, rising edge
//   rst         in   1             reset, asynchronous, active-high
//   i_req       in   1             fetch request, held until i_done/i_err
//   i_addr      in   log2(SIZE)    fetch byte address
//   i_rdata     out  N             fetched word, valid with i_done, held after
//   i_done      out  1             1-cycle pulse: fetch complete
//   i_err       out  1             1-cycle pulse: fetch misaligned, no access made
//   d_req       in   1             load/store request, held until d_done
//   d_we        in   1             1 = store, 0 = load
//   d_funct3    in   3             size: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   d_addr      in   log2(SIZE)    load/store byte address
//   d_wdata     in   N             store data; low byte/half used for sb/sh
//   d_rdata     out  N             extended load data, valid with d_done, held after
//   d_done      out  1             1-cycle pulse: load/store complete (also with d_err)
//   d_err       out  1             1-cycle pulse: misaligned/illegal, memory untouched
//   ram_we      out  1             to ram.we
//   ram_addr    out  log2(SIZE)    to ram.addr (word-aligned byte address)
//   ram_wdata   out  N             to ram.data_write
//   ram_rdata   in   N             from ram.data_read (combinational read)
// BEHAVIOUR
//   Reset: state IDLE, last_grant=I, all outputs 0 (ram_we drops immediately).
//   FSM: IDLE -> ACCESS -> [MERGE] -> IDLE. done/err are registered pulses,
//   asserted in the cycle after the final access cycle, i.e. back in IDLE.
//   IDLE: arbitrate. Ignore a port whose done or err is high this cycle.
//     If only one port requests, grant it. If both request, grant the port
//     opposite last_grant. Update last_grant. Latch addr/we/funct3/wdata.
//     Then go to ACCESS. No request: stay in IDLE. ram_we=0.
//   ACCESS: ram_addr = {addr[AW-1:2],2'b00}.
//     Misaligned (h: addr[0]!=0; w/fetch: addr[1:0]!=0), or funct3 in
//       {011,110,111}, or store with funct3 in {100,101}:
//       err+done pulse next cycle (fetch: i_err only), rdata unchanged, ram_we=0.
//     Fetch/load: capture ram_rdata, select lane by addr[1:0], extend
//       (b/h sign, bu/hu zero). Pulse done next cycle. Go to IDLE.
//     sw: ram_we=1, ram_wdata=d_wdata. Pulse d_done next cycle. Go to IDLE.
//     sb/sh: capture ram_rdata into merge register. Go to MERGE.
//   MERGE: ram_we=1, ram_wdata = captured word with the addressed lane(s)
//     replaced by d_wdata[7:0]/[15:0]. Pulse d_done next cycle. Go to IDLE.
//   Latency, measured from a req granted in IDLE at cycle 0:
//     fetch, load, sw, error -> done at cycle 2; sb/sh -> done at cycle 3.
//   The requester must present stable signals until done. A req still high
//   in the done cycle is not granted until the following cycle.
//   Reset mid-operation: FSM returns to IDLE at once and the RMW is abandoned.
//     A pending MERGE write never occurs; memory keeps its pre-store value.
//   Only one ram access per cycle; a port never receives done without its req.
// TESTING
//   1 Preload 0x11223344 @0x10. Fetch 0x10 -> i_done@c2, i_rdata=0x11223344.
//   2 Same word: lb 0x13 -> 0x00000011; lh 0x12 -> 0x00001122;
//     lb of 0x80 byte -> 0xFFFFFF80; lbu of same -> 0x00000080.
//   3 sb 0xAB @0x11, then lw 0x10 -> 0x1122AB44, done@c3, one ram_we cycle.
//   4 i_req and d_req held together for 4 transactions
//     -> grants D,I,D,I; no port starved.
//   5 lw 0x12, sh 0x13, funct3=011 -> d_err+d_done, no ram_we, memory unchanged.
//   6 Assert rst during MERGE of sh 0xBEEF @0x20
//     -> memory @0x20 unchanged, outputs 0, next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one word-wide ram between the fetch (I) and load/store (D) ports,
// with sub-word loads (sign/zero extended) and sub-word stores done as read-modify-write.
module mem_arbiter #(
    parameter int N    = 32,
    parameter int SIZE = 1024,
    localparam int AW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [N-1:0]  i_rdata,
    output logic          i_done,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [AW-1:0] d_addr,
    input  logic [N-1:0]  d_wdata,
    output logic [N-1:0]  d_rdata,
    output logic          d_done,
    output logic          d_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [N-1:0]  ram_wdata,
    input  logic [N-1:0]  ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;   // 1: D port held the most recent grant
    logic          gnt_d_q, gnt_d_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  merge_q, merge_d;
    logic [N-1:0]  i_rdata_q, i_rdata_d;
    logic [N-1:0]  d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          i_err_q, i_err_d;
    logic          d_done_q, d_done_d;
    logic          d_err_q, d_err_d;

    logic          i_elig, d_elig, pick_d;
    logic          acc_err;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [N-1:0]  load_val;
    logic [N-1:0]  merge_word;
    logic [AW-1:0] word_addr;

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign i_err     = i_err_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign word_addr = {addr_q[AW-1:2], 2'b00};

    // A port completing this cycle is not eligible until the next one.
    assign i_elig = i_req && !i_done_q && !i_err_q;
    assign d_elig = d_req && !d_done_q && !d_err_q;

    // Fetches are latched as funct3=010 loads, so they share the word path below.
    always_comb begin
        byte_sel = ram_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            2'd3:    byte_sel = ram_rdata[31:24];
            default: byte_sel = ram_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        case (f3_q)
            3'b000:  load_val = {{(N-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(N-16){half_sel[15]}}, half_sel};
            3'b100:  load_val = {{(N-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(N-16){1'b0}}, half_sel};
            default: load_val = ram_rdata;
        endcase

        case (f3_q)
            3'b000:  acc_err = 1'b0;
            3'b100:  acc_err = we_q;
            3'b001:  acc_err = addr_q[0];
            3'b101:  acc_err = addr_q[0] || we_q;
            3'b010:  acc_err = |addr_q[1:0];
            default: acc_err = 1'b1;
        endcase

        merge_word = merge_q;
        if (f3_q[0]) begin
            if (addr_q[1]) merge_word[31:16] = wdata_q[15:0];
            else           merge_word[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd1:    merge_word[15:8]  = wdata_q[7:0];
                2'd2:    merge_word[23:16] = wdata_q[7:0];
                2'd3:    merge_word[31:24] = wdata_q[7:0];
                default: merge_word[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        gnt_d_d   = gnt_d_q;
        addr_d    = addr_q;
        we_d      = we_q;
        f3_d      = f3_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        i_err_d   = 1'b0;
        d_done_d  = 1'b0;
        d_err_d   = 1'b0;
        pick_d    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        case (state_q)
            IDLE: begin
                if (i_elig || d_elig) begin
                    pick_d   = d_elig && (!i_elig || !last_d_q);
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    addr_d   = pick_d ? d_addr : i_addr;
                    we_d     = pick_d && d_we;
                    f3_d     = pick_d ? d_funct3 : 3'b010;
                    wdata_d  = d_wdata;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = word_addr;
                state_d  = IDLE;
                if (acc_err) begin
                    if (gnt_d_q) begin
                        d_err_d  = 1'b1;
                        d_done_d = 1'b1;
                    end else begin
                        i_err_d  = 1'b1;
                    end
                end else if (!we_q) begin
                    if (gnt_d_q) begin
                        d_rdata_d = load_val;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = load_val;
                        i_done_d  = 1'b1;
                    end
                end else if (f3_q == 3'b010) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                    d_done_d  = 1'b1;
                end else begin
                    merge_d = ram_rdata;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                ram_addr  = word_addr;
                ram_we    = 1'b1;
                ram_wdata = merge_word;
                d_done_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            gnt_d_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            wdata_q   <= '0;
            merge_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            gnt_d_q   <= gnt_d_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            i_err_q   <= i_err_d;
            d_done_q  <= d_done_d;
            d_err_q   <= d_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural ram, byte-array reference model, vector table,
// randomized traffic and hand-written arbitration / reset-during-merge sequences.
module tb_mem_arbiter;

    localparam int SIZE = 1024;
    localparam int AW   = 10;

    logic          clk, rst;
    logic          i_req, i_done, i_err;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          d_req, d_we, d_done, d_err;
    logic [2:0]    d_funct3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    mem_arbiter #(.N(32), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:SIZE/4-1];
    assign ram_rdata = ram[ram_addr[AW-1:2]];
    always @(posedge clk) if (ram_we) ram[ram_addr[AW-1:2]] <= ram_wdata;

    int we_cnt = 0;
    always @(negedge clk) if (ram_we) we_cnt++;

    // Reference model: memory as a flat byte array plus the last value each port returned.
    logic [7:0]  refm [0:SIZE-1];
    logic [31:0] last_i, last_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
    endfunction

    task automatic init_mem();
        logic [31:0] v;
        for (int w = 0; w < SIZE/4; w++) begin
            v = (w * 32'h01030507) ^ 32'h5A5A0000;
            if (w == 4) v = 32'h11223344;
            if (w == 5) v = 32'hC3A58000;
            if (w == 8) v = 32'h01020304;
            ram[w] = v;
            for (int k = 0; k < 4; k++) refm[4*w+k] = v[8*k +: 8];
        end
    endtask

    task automatic chk_mem(input string name);
        int bad;
        bad = 0;
        for (int w = 0; w < SIZE/4; w++)
            if (ram[w] !== ref_word(4*w)) bad++;
        chk(name, bad, 0);
    endtask

    // Expected outcome of one request, straight from the access rules; updates the model.
    task automatic model(input bit port, input bit we, input logic [2:0] f3, input int addr,
                         input logic [31:0] wd, output logic [31:0] rd, output bit err,
                         output int lat, output int wes);
        int  nb;
        bit  bad;
        logic [31:0] v;
        nb  = port ? (1 << f3[1:0]) : 4;
        bad = port ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]) || (addr % nb != 0))
                   : (addr % 4 != 0);
        err = 0; lat = 2; wes = 0;
        if (bad) begin
            err = 1;
            rd  = port ? last_d : last_i;
        end else if (!port || !we) begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(refm[addr+k]) << (8*k));
            if (port && !f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
            rd = v;
            if (port) last_d = v; else last_i = v;
        end else begin
            for (int k = 0; k < nb; k++) refm[addr+k] = wd[8*k +: 8];
            rd  = last_d;
            wes = 1;
            lat = (nb == 4) ? 2 : 3;
        end
    endtask

    task automatic run_op(input bit port, input bit we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output bit err,
                          output int lat, output int wes, output bit stray);
        int  w0;
        bit  got;
        @(posedge clk); #1;
        w0 = we_cnt;
        if (port) begin
            d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        lat = 0; got = 0; stray = 0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (port) begin
                got   = d_done;
                stray = stray | i_done | i_err;
            end else begin
                got   = i_done | i_err;
                stray = stray | d_done | d_err;
            end
        end
        rd  = port ? d_rdata : i_rdata;
        err = port ? d_err : i_err;
        wes = we_cnt - w0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_i = 0; last_d = 0;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] rd, m_rd;
    bit          err, m_err, stray;
    int          lat, wes, m_lat, m_wes;
    int          order[$];

    initial begin
        tbl.push_back('{0, 0, 3'b010, 10'h10, 32'h0,        32'h11223344, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b000, 10'h13, 32'h0,        32'h00000011, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b001, 10'h12, 32'h0,        32'h00001122, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b000, 10'h15, 32'h0,        32'hFFFFFF80, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b100, 10'h15, 32'h0,        32'h00000080, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b001, 10'h16, 32'h0,        32'hFFFFC3A5, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b101, 10'h16, 32'h0,        32'h0000C3A5, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b010, 10'h14, 32'h0,        32'hC3A58000, 0, 2, 0});
        tbl.push_back('{1, 1, 3'b000, 10'h11, 32'hDEADBEAB, 32'hC3A58000, 0, 3, 1});
        tbl.push_back('{1, 0, 3'b010, 10'h10, 32'h0,        32'h1122AB44, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b010, 10'h12, 32'h0,        32'h1122AB44, 1, 2, 0});
        tbl.push_back('{1, 1, 3'b001, 10'h13, 32'h12345678, 32'h1122AB44, 1, 2, 0});
        tbl.push_back('{1, 0, 3'b011, 10'h10, 32'h0,        32'h1122AB44, 1, 2, 0});
        tbl.push_back('{1, 1, 3'b100, 10'h10, 32'h00000001, 32'h1122AB44, 1, 2, 0});
        tbl.push_back('{1, 0, 3'b111, 10'h10, 32'h0,        32'h1122AB44, 1, 2, 0});
        tbl.push_back('{0, 0, 3'b010, 10'h12, 32'h0,        32'h11223344, 1, 2, 0});
        tbl.push_back('{1, 1, 3'b001, 10'h12, 32'h5555BEEF, 32'h1122AB44, 0, 3, 1});
        tbl.push_back('{1, 0, 3'b010, 10'h10, 32'h0,        32'hBEEFAB44, 0, 2, 0});
        tbl.push_back('{1, 1, 3'b010, 10'h18, 32'hCAFEF00D, 32'hBEEFAB44, 0, 2, 1});
        tbl.push_back('{0, 0, 3'b010, 10'h18, 32'h0,        32'hCAFEF00D, 0, 2, 0});
        tbl.push_back('{1, 0, 3'b001, 10'h1A, 32'h0,        32'hFFFFCAFE, 0, 2, 0});

        i_addr = '0; d_we = 0; d_funct3 = 3'b010; d_addr = '0; d_wdata = '0;
        init_mem();
        do_reset();
        rst = 1'b1;
        #1;
        chk("reset_outputs", {i_rdata, i_done, i_err, d_rdata, d_done, d_err, ram_we, ram_addr, ram_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[n]) begin
            model(tbl[n].port, tbl[n].we, tbl[n].f3, int'(tbl[n].addr), tbl[n].wd, m_rd, m_err, m_lat, m_wes);
            run_op(tbl[n].port, tbl[n].we, tbl[n].f3, tbl[n].addr, tbl[n].wd, rd, err, lat, wes, stray);
            chk($sformatf("vec%0d_rdata", n), rd, tbl[n].exp_rd);
            chk($sformatf("vec%0d_err", n), err, tbl[n].exp_err);
            chk($sformatf("vec%0d_latency", n), lat, tbl[n].exp_lat);
            chk($sformatf("vec%0d_ram_we_cycles", n), wes, tbl[n].exp_wes);
            chk($sformatf("vec%0d_other_port_quiet", n), stray, 0);
        end
        chk_mem("mem_after_table");

        for (int n = 0; n < 300; n++) begin
            bit          p, w;
            logic [2:0]  f;
            logic [9:0]  a;
            logic [31:0] wd;
            p  = 1'($urandom_range(0, 2) != 0);
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            a  = 10'($urandom_range(0, 63));
            wd = $urandom;
            model(p, w, f, int'(a), wd, m_rd, m_err, m_lat, m_wes);
            run_op(p, w, f, a, wd, rd, err, lat, wes, stray);
            if (rd !== m_rd || err !== m_err || lat != m_lat || wes != m_wes || stray) begin
                errors++;
                $display("FAIL rand%0d p=%0d we=%0d f3=%0d a=%h: got rd=%h err=%0d lat=%0d we=%0d stray=%0d expected rd=%h err=%0d lat=%0d we=%0d",
                         n, p, w, f, a, rd, err, lat, wes, stray, m_rd, m_err, m_lat, m_wes);
            end
            checks++;
        end
        chk_mem("mem_after_random");

        // sh abandoned by reset while in MERGE: memory must keep its old word
        @(posedge clk); #1;
        d_we = 1; d_funct3 = 3'b001; d_addr = 10'h20; d_wdata = 32'h0000BEEF; d_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("merge_write_pending", ram_we, 1);
        rst = 1'b1; d_req = 0;
        #1;
        chk("reset_mid_merge_outputs", {i_rdata, i_done, i_err, d_rdata, d_done, d_err, ram_we, ram_addr, ram_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_i = 0; last_d = 0;
        chk("reset_mid_merge_word", ram[8], ref_word(32'h20));
        chk_mem("mem_after_abandoned_rmw");
        model(1, 0, 3'b010, 32'h20, 32'h0, m_rd, m_err, m_lat, m_wes);
        run_op(1, 0, 3'b010, 10'h20, 32'h0, rd, err, lat, wes, stray);
        chk("post_reset_lw_rdata", rd, m_rd);
        chk("post_reset_lw_latency", lat, m_lat);

        // both ports held continuously from reset: D wins first, then strict alternation
        do_reset();
        i_addr = 10'h10; d_we = 0; d_funct3 = 3'b010; d_addr = 10'h14;
        i_req = 1; d_req = 1;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(posedge clk); #1;
            if (d_done) order.push_back(1);
            if (i_done) order.push_back(0);
            if (i_done && d_done) chk("dual_done_same_cycle", 1, 0);
        end
        i_req = 0; d_req = 0;
        chk("arb_grant_count", order.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("arb_grant%0d_is_d", k), (k < order.size()) ? order[k] : -1, (k % 2 == 0) ? 1 : 0);
        chk("arb_i_rdata", i_rdata, ref_word(32'h10));
        chk("arb_d_rdata", d_rdata, ref_word(32'h14));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
